// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// State codes, coin encodings, coin unit value and a coin decode helper.
package vend_pkg;

  typedef logic [2:0] vend_state_t;

  localparam vend_state_t StIdle     = 3'd0;
  localparam vend_state_t StCollect  = 3'd1;
  localparam vend_state_t StDispense = 3'd2;
  localparam vend_state_t StChange   = 3'd3;
  localparam vend_state_t StGap      = 3'd4;

  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;

  localparam int unsigned COIN_UNIT = 5;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] val;
    val = 4'd0;
    case (code)
      COIN_5:  val = 4'(COIN_UNIT);
      COIN_10: val = 4'(2 * COIN_UNIT);
      default: val = 4'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_hopper_if.sv
// Change hopper handshake: one chg_req/chg_ack exchange per 5 Rs coin,
// with a one-cycle gap between coins. Reports each accepted coin and the last one.
module vend_change_hopper_if
  import vend_pkg::*;
#(
  parameter int unsigned CreditW = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [CreditW-1:0] credit_i,
  input  logic               chg_ack_i,
  output logic               chg_req_o,
  output logic               dec_o,
  output logic               done_o
);

  localparam logic [CreditW-1:0] UnitC = CreditW'(COIN_UNIT);

  vend_state_t hop_q, hop_d;
  logic        chg_req_q, chg_req_d;

  always_comb begin
    hop_d  = hop_q;
    dec_o  = 1'b0;
    done_o = 1'b0;
    case (hop_q)
      StIdle: begin
        if (start_i) hop_d = StChange;
      end
      StChange: begin
        if (chg_ack_i) begin
          dec_o = 1'b1;
          if (credit_i > UnitC) begin
            hop_d = StGap;
          end else begin
            hop_d  = StIdle;
            done_o = 1'b1;
          end
        end
      end
      StGap:   hop_d = StChange;
      default: hop_d = StIdle;
    endcase
    chg_req_d = (hop_d == StChange);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hop_q     <= StIdle;
      chg_req_q <= 1'b0;
    end else begin
      hop_q     <= hop_d;
      chg_req_q <= chg_req_d;
    end
  end

  assign chg_req_o = chg_req_q;

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin collection, dispense handshake and change refund.
// Optional COLLECT inactivity timeout is enabled by defining VEND_TIMEOUT_EN.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 15,
  parameter int unsigned CREDIT_W    = 7,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                disp_req,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UnitC  = CREDIT_W'(COIN_UNIT);

  // StChange here covers both CHANGE and GAP; the hopper tracks which one.
  vend_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, coin_val;
  logic                disp_req_q, disp_req_d;
  logic                coin_rej_q, coin_rej_d;
  logic                busy_q, busy_d;
  logic                coin_vld, hop_start, hop_dec, hop_done;

  assign coin_val = CREDIT_W'(coin_value(coin));
  assign coin_vld = (coin == COIN_5) || (coin == COIN_10);

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              timeout;
  assign timeout = (timer_q == TimerW'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    disp_req_d = disp_req_q;
    coin_rej_d = 1'b0;
    hop_start  = 1'b0;
`ifdef VEND_TIMEOUT_EN
    timer_d    = '0;
`endif
    case (state_q)
      StIdle: begin
        if (coin_vld) begin
          credit_d = credit_q + coin_val;
          state_d  = StCollect;
        end
      end
      StCollect: begin
        if (cancel) begin
          coin_rej_d = coin_vld;
          hop_start  = 1'b1;
          state_d    = StChange;
        end else if (coin_vld) begin
          credit_d = credit_q + coin_val;
          if (credit_d >= PriceC) begin
            state_d    = StDispense;
            disp_req_d = 1'b1;
          end
        end else if (credit_q >= PriceC) begin
          // Reached only when a single IDLE coin already covers PRICE.
          state_d    = StDispense;
          disp_req_d = 1'b1;
`ifdef VEND_TIMEOUT_EN
        end else if (timeout) begin
          hop_start = 1'b1;
          state_d   = StChange;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      StDispense: begin
        coin_rej_d = coin_vld;
        if (disp_ack) begin
          disp_req_d = 1'b0;
          credit_d   = credit_q - PriceC;
          if (credit_d != '0) begin
            hop_start = 1'b1;
            state_d   = StChange;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StChange: begin
        coin_rej_d = coin_vld;
        if (hop_dec) credit_d = credit_q - UnitC;
        if (hop_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StDispense) || (state_d == StChange);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      disp_req_q <= 1'b0;
      coin_rej_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      disp_req_q <= disp_req_d;
      coin_rej_q <= coin_rej_d;
      busy_q     <= busy_d;
`ifdef VEND_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  vend_change_hopper_if #(
    .CreditW (CREDIT_W)
  ) u_hopper (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (hop_start),
    .credit_i  (credit_q),
    .chg_ack_i (chg_ack),
    .chg_req_o (chg_req),
    .dec_o     (hop_dec),
    .done_o    (hop_done)
  );

  assign disp_req = disp_req_q;
  assign coin_rej = coin_rej_q;
  assign credit   = credit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random
// stimulus against a behavioural model. Timeout scenario needs VEND_TIMEOUT_EN.
module tb_vend_controller;

  localparam int unsigned PRICE       = 15;
  localparam int unsigned CREDIT_W    = 7;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          coin = 2'b00;
  logic                cancel = 1'b0;
  logic                disp_ack = 1'b0;
  logic                chg_ack = 1'b0;
  logic                disp_req, chg_req, coin_rej, busy;
  logic [CREDIT_W-1:0] credit;

  // Observation vector: {disp_req, chg_req, coin_rej, busy, credit}
  logic [10:0] obs;
  logic [10:0] exp_v;
  assign obs = {disp_req, chg_req, coin_rej, busy, credit};

  int errors = 0;
  int checks = 0;

  vend_controller #(
    .PRICE       (PRICE),
    .CREDIT_W    (CREDIT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coin     (coin),
    .cancel   (cancel),
    .disp_req (disp_req),
    .disp_ack (disp_ack),
    .chg_req  (chg_req),
    .chg_ack  (chg_ack),
    .coin_rej (coin_rej),
    .credit   (credit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase of the vending transaction and money held.
  typedef enum int {MIdle, MCollect, MVend, MRefund, MPause} mphase_e;
  mphase_e m_phase = MIdle;
  int      m_credit = 0;
  int      m_quiet = 0;
  bit      m_rej = 1'b0;

  task automatic model_reset();
    m_phase  = MIdle;
    m_credit = 0;
    m_quiet  = 0;
    m_rej    = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic x, input logic da,
                            input logic ca);
    int v;
    v = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
    m_rej = 1'b0;
    case (m_phase)
      MIdle: if (v > 0) begin
        m_credit += v;
        m_phase = MCollect;
        m_quiet = 0;
      end
      MCollect: begin
        if (x) begin
          m_rej   = (v > 0);
          m_phase = MRefund;
        end else if (v > 0) begin
          m_credit += v;
          m_quiet = 0;
          if (m_credit >= PRICE) m_phase = MVend;
        end else begin
`ifdef VEND_TIMEOUT_EN
          m_quiet++;
          if (m_quiet == TIMEOUT_CYC) m_phase = MRefund;
`endif
        end
      end
      MVend: begin
        m_rej = (v > 0);
        if (da) begin
          m_credit -= PRICE;
          m_phase = (m_credit > 0) ? MRefund : MIdle;
        end
      end
      MRefund: begin
        m_rej = (v > 0);
        if (ca) begin
          m_credit -= 5;
          m_phase = (m_credit > 0) ? MPause : MIdle;
        end
      end
      MPause: begin
        m_rej   = (v > 0);
        m_phase = MRefund;
      end
      default: m_phase = MIdle;
    endcase
  endtask

  function automatic logic [10:0] model_obs();
    return {m_phase == MVend, m_phase == MRefund, m_rej,
            m_phase inside {MVend, MRefund, MPause}, 7'(m_credit)};
  endfunction

  task automatic tick(input logic [1:0] c, input logic x, input logic da, input logic ca);
    coin = c; cancel = x; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    model_step(c, x, da, ca);
    #1;
    coin = 2'b00; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_state: obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(2'b00, 1'b1, 1'b0, 1'b0);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_cancel: obs=%b exp=%b", obs, exp_v); end
    tick(2'b11, 1'b0, 1'b1, 1'b1);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_coin11: obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_exact_price();
    tick(2'b01, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b0000, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL collect_5: obs=%b exp=%b", obs, exp_v); end
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b1001, 7'd15}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reach_price: obs=%b exp=%b", obs, exp_v); end
    repeat (3) tick(2'b00, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b1001, 7'd15}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL disp_held: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b1, 1'b0);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL exact_done: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL exact_no_chg: obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_change();
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b1001, 7'd20}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL credit_20: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    exp_v = {4'b1001, 7'd20}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stray_chg_ack: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b1, 1'b0);
    exp_v = {4'b0101, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL change_start: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b1, 1'b0);
    exp_v = {4'b0101, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stray_disp_ack: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL change_done: obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_cancel();
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b0, 1'b0);
    exp_v = {4'b0101, 7'd10}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cancel_refund: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    exp_v = {4'b0001, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL refund_gap: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    exp_v = {4'b0101, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL gap_ack_ignored: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL refund_done: obs=%b exp=%b", obs, exp_v); end
    tick(2'b01, 1'b0, 1'b0, 1'b0);
    tick(2'b10, 1'b1, 1'b0, 1'b0);
    exp_v = {4'b0111, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cancel_wins: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cancel_coin_done: obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_coin_reject();
    tick(2'b01, 1'b0, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b1011, 7'd15}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rej_pulse: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b1001, 7'd15}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rej_one_cycle: obs=%b exp=%b", obs, exp_v); end
    tick(2'b11, 1'b1, 1'b0, 1'b0);
    exp_v = {4'b1001, 7'd15}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL busy_coin11_cancel: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b1, 1'b0);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rej_vend_done: obs=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #2;
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset_disp: obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b1, 1'b0);
    exp_v = {4'b0101, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL post_reset_vend: obs=%b exp=%b", obs, exp_v); end
    #3;
    rst_n = 1'b0;
    #2;
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset_chg: obs=%b exp=%b", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    tick(2'b01, 1'b0, 1'b0, 1'b0);
    repeat (TIMEOUT_CYC - 1) tick(2'b00, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b0000, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL timeout_early: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b0);
    exp_v = {4'b0101, 7'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL timeout_change: obs=%b exp=%b", obs, exp_v); end
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    exp_v = 11'd0; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL timeout_done: obs=%b exp=%b", obs, exp_v); end
  endtask
`endif

  task automatic test_random();
    int          r;
    int          shown;
    logic [1:0]  c;
    logic        x, da, ca;
    shown = 0;
    for (int i = 0; i < 2000; i++) begin
      r  = $urandom_range(0, 9);
      c  = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      x  = ($urandom_range(0, 15) == 0);
      da = ($urandom_range(0, 2) == 0);
      ca = ($urandom_range(0, 2) == 0);
      tick(c, x, da, ca);
      exp_v = model_obs();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d: obs=%b exp=%b", i, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_coin_reject();
    test_async_reset();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
